// File: rtl/flow_led_pkg.sv
// ============================================================================
// flow_led_pkg : shared mode and state encodings for the flow LED sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package flow_led_pkg;

  localparam logic [1:0] MODE_SHIFT  = 2'd0;
  localparam logic [1:0] MODE_BOUNCE = 2'd1;
  localparam logic [1:0] MODE_BLINK  = 2'd2;
  localparam logic [1:0] MODE_FILL   = 2'd3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/flow_led_next.sv
// ============================================================================
// flow_led_next : combinational next-pattern / next-direction generator
// Revision: 1.0
// ============================================================================
`default_nettype none

module flow_led_next
  import flow_led_pkg::*;
#(
  parameter int NUM = 8
) (
  input  logic [NUM-1:0] pat_i,
  input  logic [1:0]     mode_i,
  input  logic           dir_i,   // 1 = moving toward the MSB
  output logic [NUM-1:0] pat_o,
  output logic           dir_o
);

  logic [NUM-1:0] w_shift;
  logic [NUM-1:0] w_bounce_pat;
  logic           w_bounce_dir;

  always_comb begin
    w_shift = '0;
    for (int i = 0; i < NUM; i++) begin
      w_shift[i] = pat_i[(i + NUM - 1) % NUM];
    end
  end

  generate
    if (NUM == 1) begin : g_bounce_one
      assign w_bounce_pat = pat_i;
      assign w_bounce_dir = dir_i;
    end else begin : g_bounce_multi
      logic w_up;
      // Direction is re-derived from the ends so the one-hot can never run off an edge.
      assign w_up         = dir_i ? !pat_i[NUM-1] : pat_i[0];
      assign w_bounce_pat = w_up ? (pat_i << 1) : (pat_i >> 1);
      assign w_bounce_dir = w_bounce_pat[NUM-1] ? 1'b0 :
                            (w_bounce_pat[0] ? 1'b1 : w_up);
    end
  endgenerate

  always_comb begin
    pat_o = pat_i;
    dir_o = dir_i;
    case (mode_i)
      MODE_SHIFT:  pat_o = w_shift;
      MODE_BOUNCE: begin
        pat_o = w_bounce_pat;
        dir_o = w_bounce_dir;
      end
      MODE_BLINK:  pat_o = (pat_i == '0) ? {NUM{1'b1}} : '0;
      default:     pat_o = (&pat_i) ? NUM'(1) : ((pat_i << 1) | NUM'(1));
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/flow_led_seq.sv
// ============================================================================
// flow_led_seq : alarm light sequencer (FSM, step counter, latches, outputs)
// Revision: 1.0
// ============================================================================
`default_nettype none

module flow_led_seq
  import flow_led_pkg::*;
#(
  parameter int NUM   = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             power,
  input  logic             sig_ring,
  input  logic             sig_step,
  input  logic [1:0]       mode,
  input  logic [LEN_W-1:0] run_len,
  input  logic             stop,
  output logic [NUM-1:0]   alarm_light,
  output logic             busy,
  output logic             done
);

  logic [0:0]       state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic [NUM-1:0]   light_q, light_d;
  logic             done_q, done_d;

  logic [NUM-1:0]   w_next_pat;
  logic             w_next_dir;
  logic [NUM-1:0]   w_init_pat;
  logic [LEN_W:0]   w_count_inc;

  flow_led_next #(.NUM(NUM)) u_next (
    .pat_i  (light_q),
    .mode_i (mode_q),
    .dir_i  (dir_q),
    .pat_o  (w_next_pat),
    .dir_o  (w_next_dir)
  );

  assign w_init_pat  = (mode == MODE_BLINK) ? {NUM{1'b1}} : NUM'(1);
  assign w_count_inc = {1'b0, count_q} + 1'b1;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    count_d = count_q;
    dir_d   = dir_q;
    light_d = light_q;
    done_d  = 1'b0;
    if (!power) begin
      state_d = ST_IDLE;
      light_d = '0;
      count_d = '0;
    end else if (sig_ring) begin
      state_d = ST_RUN;
      mode_d  = mode;
      len_d   = run_len;
      count_d = '0;
      dir_d   = 1'b1;
      light_d = w_init_pat;
    end else if (stop && state_q == ST_RUN) begin
      state_d = ST_IDLE;
      light_d = '0;
    end else if (sig_step && state_q == ST_RUN) begin
      if (len_q != '0 && w_count_inc == {1'b0, len_q}) begin
        state_d = ST_IDLE;
        light_d = '0;
        done_d  = 1'b1;
      end else begin
        // Saturation only matters in continuous mode; counted runs end first.
        count_d = (&count_q) ? count_q : w_count_inc[LEN_W-1:0];
        light_d = w_next_pat;
        dir_d   = w_next_dir;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_SHIFT;
      len_q   <= '0;
      count_q <= '0;
      dir_q   <= 1'b1;
      light_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      light_q <= light_d;
      done_q  <= done_d;
    end
  end

  assign alarm_light = light_q;
  assign busy        = (state_q == ST_RUN);
  assign done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_flow_led_seq.sv
// ============================================================================
// tb_flow_led_seq : directed scenarios plus random stimulus against a model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_flow_led_seq;

  logic       clk = 1'b0;
  logic       rst, power, sig_ring, sig_step, stop;
  logic [1:0] mode;
  logic [7:0] run_len;
  logic [3:0] l4;
  logic [4:0] l5;
  logic       busy4, done4, busy5, done5;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  flow_led_seq #(.NUM(4), .LEN_W(8)) u4 (
    .clk(clk), .rst(rst), .power(power), .sig_ring(sig_ring), .sig_step(sig_step),
    .mode(mode), .run_len(run_len), .stop(stop),
    .alarm_light(l4), .busy(busy4), .done(done4)
  );

  flow_led_seq #(.NUM(5), .LEN_W(8)) u5 (
    .clk(clk), .rst(rst), .power(power), .sig_ring(sig_ring), .sig_step(sig_step),
    .mode(mode), .run_len(run_len), .stop(stop),
    .alarm_light(l5), .busy(busy5), .done(done5)
  );

  task automatic cyc(input logic r, input logic pw, input logic ring, input logic step,
                     input logic stp, input logic [1:0] md, input logic [7:0] len);
    rst = r; power = pw; sig_ring = ring; sig_step = step; stop = stp;
    mode = md; run_len = len;
    @(posedge clk);
    #1;
  endtask

  // Pattern shown after k advances, from the mode's closed-form rule.
  function automatic logic [7:0] exp_pat(input int num, input int md, input int k);
    int p, per;
    case (md)
      0: return 8'(1 << (k % num));
      1: begin
        if (num == 1) return 8'd1;
        per = 2 * (num - 1);
        p = k % per;
        if (p >= num) p = per - p;
        return 8'(1 << p);
      end
      2: return (k % 2 == 0) ? 8'((1 << num) - 1) : 8'd0;
      default: begin
        p = k % num;
        return 8'((1 << (p + 1)) - 1);
      end
    endcase
  endfunction

  task automatic test_reset;
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 0, 0, 3);
    n_checks++;
    if ({l4, busy4, done4, l5, busy5, done5} !== 12'd0) begin
      n_errors++;
      $display("FAIL reset: l4=%b b4=%b d4=%b l5=%b b5=%b d5=%b required all 0",
               l4, busy4, done4, l5, busy5, done5);
    end
  endtask

  task automatic test_shift;
    logic [4:0] e [6] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00000};
    cyc(0, 1, 1, 0, 0, 2'd0, 8'd5);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) cyc(0, 1, 0, 1, 0, 2'($urandom), 8'($urandom));
      n_checks++;
      if (l5 !== e[k] || busy5 !== (k < 5) || done5 !== (k == 5)) begin
        n_errors++;
        $display("FAIL shift step %0d: lights=%b busy=%b done=%b required %b %b %b",
                 k, l5, busy5, done5, e[k], k < 5, k == 5);
      end
    end
    cyc(0, 1, 0, 0, 0, 0, 0);
    n_checks++;
    if (done5 !== 1'b0) begin
      n_errors++;
      $display("FAIL shift done width: done=%b required 0", done5);
    end
  endtask

  task automatic test_bounce;
    logic [3:0] e [9] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100,
                          4'b0010, 4'b0001, 4'b0010, 4'b0000};
    cyc(0, 1, 1, 0, 0, 2'd1, 8'd8);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) cyc(0, 1, 0, 1, 0, 2'($urandom), 8'($urandom));
      n_checks++;
      if (l4 !== e[k] || busy4 !== (k < 8) || done4 !== (k == 8)) begin
        n_errors++;
        $display("FAIL bounce step %0d: lights=%b busy=%b done=%b required %b %b %b",
                 k, l4, busy4, done4, e[k], k < 8, k == 8);
      end
    end
  endtask

  task automatic test_fill;
    logic [3:0] e [7] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0001, 4'b0011, 4'b0111};
    cyc(0, 1, 1, 0, 0, 2'd3, 8'd0);
    for (int k = 0; k < 7; k++) begin
      if (k > 0) cyc(0, 1, 0, 1, 0, 2'd0, 8'd1);
      n_checks++;
      if (l4 !== e[k] || busy4 !== 1'b1 || done4 !== 1'b0) begin
        n_errors++;
        $display("FAIL fill step %0d: lights=%b busy=%b done=%b required %b 1 0",
                 k, l4, busy4, done4, e[k]);
      end
    end
    cyc(0, 1, 0, 1, 1, 0, 0);
    n_checks++;
    if (l4 !== 4'b0000 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      n_errors++;
      $display("FAIL fill stop: lights=%b busy=%b done=%b required 0000 0 0", l4, busy4, done4);
    end
  endtask

  task automatic test_blink_retrigger;
    logic [3:0] want;
    cyc(0, 1, 1, 0, 0, 2'd2, 8'd10);
    for (int k = 1; k <= 3; k++) cyc(0, 1, 0, 1, 0, 0, 0);
    cyc(0, 1, 1, 1, 0, 2'd2, 8'd10);
    n_checks++;
    if (l4 !== 4'b1111 || busy4 !== 1'b1 || done4 !== 1'b0) begin
      n_errors++;
      $display("FAIL blink retrigger: lights=%b busy=%b done=%b required 1111 1 0",
               l4, busy4, done4);
    end
    for (int k = 1; k <= 10; k++) begin
      cyc(0, 1, 0, 1, 0, 0, 0);
      want = (k == 10) ? 4'b0000 : ((k % 2 == 0) ? 4'b1111 : 4'b0000);
      n_checks++;
      if (l4 !== want || done4 !== (k == 10) || busy4 !== (k < 10)) begin
        n_errors++;
        $display("FAIL blink step %0d: lights=%b busy=%b done=%b required %b %b %b",
                 k, l4, busy4, done4, want, k < 10, k == 10);
      end
    end
  endtask

  task automatic test_power;
    cyc(0, 1, 1, 0, 0, 2'd0, 8'd10);
    cyc(0, 1, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    n_checks++;
    if (l4 !== 4'b0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      n_errors++;
      $display("FAIL power off: lights=%b busy=%b done=%b required 0000 0 0", l4, busy4, done4);
    end
    cyc(0, 1, 0, 1, 0, 0, 0);
    n_checks++;
    if (l4 !== 4'b0 || busy4 !== 1'b0) begin
      n_errors++;
      $display("FAIL power resume step: lights=%b busy=%b required 0000 0", l4, busy4);
    end
  endtask

  task automatic test_rst_ring;
    cyc(0, 1, 1, 0, 0, 2'd3, 8'd9);
    cyc(0, 1, 0, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 2'd3, 8'd9);
    n_checks++;
    if ({l4, busy4, done4, l5, busy5, done5} !== 12'd0) begin
      n_errors++;
      $display("FAIL rst with ring: l4=%b b4=%b l5=%b b5=%b required all 0", l4, busy4, l5, busy5);
    end
  endtask

  task automatic test_random;
    int       nums [2] = '{4, 5};
    bit       act [2];
    bit       dn [2];
    int       mm [2], ml [2], mk [2];
    logic     r, pw, ring, step, stp;
    logic [1:0] md;
    logic [7:0] len, got, want;
    logic     gb, gd;
    cyc(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin act[i] = 0; dn[i] = 0; mm[i] = 0; ml[i] = 0; mk[i] = 0; end
    for (int c = 0; c < 600; c++) begin
      r    = ($urandom_range(99) == 0);
      pw   = ($urandom_range(39) != 0);
      ring = ($urandom_range(14) == 0);
      stp  = ($urandom_range(24) == 0);
      step = $urandom_range(1);
      md   = 2'($urandom);
      len  = 8'($urandom_range(6));
      cyc(r, pw, ring, step, stp, md, len);
      for (int i = 0; i < 2; i++) begin
        dn[i] = 0;
        if (r || !pw) act[i] = 0;
        else if (ring) begin act[i] = 1; mm[i] = md; ml[i] = len; mk[i] = 0; end
        else if (stp && act[i]) act[i] = 0;
        else if (step && act[i]) begin
          if (ml[i] != 0 && mk[i] + 1 == ml[i]) begin act[i] = 0; dn[i] = 1; end
          else mk[i]++;
        end
        want = act[i] ? exp_pat(nums[i], mm[i], mk[i]) : 8'd0;
        got  = (i == 0) ? {4'd0, l4} : {3'd0, l5};
        gb   = (i == 0) ? busy4 : busy5;
        gd   = (i == 0) ? done4 : done5;
        n_checks++;
        if (got !== want || gb !== act[i] || gd !== dn[i]) begin
          n_errors++;
          $display("FAIL random cyc %0d NUM=%0d: lights=%b busy=%b done=%b required %b %b %b",
                   c, nums[i], got, gb, gd, want, act[i], dn[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; power = 1'b1; sig_ring = 1'b0; sig_step = 1'b0; stop = 1'b0;
    mode = 2'd0; run_len = 8'd0;
    test_reset();
    test_shift();
    test_bounce();
    test_fill();
    test_blink_retrigger();
    test_power();
    test_rst_ring();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
